// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Contents:
//   NIBBLE_W          width of one displayed hex digit
//   DEFAULT_SCAN_DIV  default clock cycles per digit slot
//   DEFAULT_GUARD     default blanked cycles at the start of each slot
//   MAX_DIGITS        largest supported digit count
//   DIG_ALL_OFF       active-low enable pattern with every digit dark
//   idx_w()/cnt_w()   register widths for the digit index and prescaler
package seg_pkg;

  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned DEFAULT_SCAN_DIV = 50000;
  localparam int unsigned DEFAULT_GUARD    = 2;
  localparam int unsigned MAX_DIGITS       = 8;

  localparam logic [MAX_DIGITS-1:0] DIG_ALL_OFF = '1;

  // Width of the digit index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned num_digits);
    return (num_digits <= 2) ? 1 : $clog2(num_digits);
  endfunction

  // Width of a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Free-running modulo-SCAN_DIV counter that paces the digit slots.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   count  current count, 0..SCAN_DIV-1
//   tick   high while count is at SCAN_DIV-1 (last cycle of a slot)
module seg_scan_prescaler
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [cnt_w(SCAN_DIV)-1:0]  count,
  output logic                        tick
);

  localparam int unsigned    CW   = cnt_w(SCAN_DIV);
  localparam logic [CW-1:0]  LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tick  = (count_q == LAST);

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed scan driver for a NUM_DIGITS-digit common-anode 7-segment display.
// A loaded value waits in a shadow register and is promoted to the display
// register only at a frame boundary, so a frame never shows a mix of two values.
// Optional feature: define SEG_LZB_EN for leading-zero blanking.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   load     1-cycle write strobe, samples data_in
//   data_in  packed nibbles, [3:0] = digit 0 (rightmost)
//   digit    nibble of the current slot, to the segment decoder
//   dig_en   active-low digit enables, at most one bit low
//   blank    high when no digit is enabled
//   frame    1-cycle pulse after each frame boundary
//   pending  shadow holds a value not yet displayed
module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = DEFAULT_SCAN_DIV,
  parameter int unsigned GUARD      = DEFAULT_GUARD
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] data_in,
  output logic [NIBBLE_W-1:0]            digit,
  output logic [NUM_DIGITS-1:0]          dig_en,
  output logic                           blank,
  output logic                           frame,
  output logic                           pending
);

  localparam int unsigned IW = idx_w(NUM_DIGITS);
  localparam int unsigned CW = cnt_w(SCAN_DIV);
  localparam int unsigned DW = NIBBLE_W * NUM_DIGITS;

  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]         GUARD_C  = CW'(GUARD);
  localparam logic [NUM_DIGITS-1:0] EN_OFF   = DIG_ALL_OFF[NUM_DIGITS-1:0];

  // Slot pacing
  logic [CW-1:0] presc;
  logic          tick;

  seg_scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .count (presc),
    .tick  (tick)
  );

  // Scan and value state
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] display_q, display_d;
  logic          pending_q, pending_d;
  logic          boundary;

  assign boundary = tick && (idx_q == LAST_IDX);

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        // Load coinciding with the boundary goes straight to the display.
        display_d = data_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        display_d = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // Per-digit view of the displayed value
  logic [NIBBLE_W-1:0] nib [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    assign nib[g] = display_q[g*NIBBLE_W +: NIBBLE_W];
  end

`ifdef SEG_LZB_EN
  // Index of the most significant non-zero digit; 0 when the value is zero,
  // which keeps digit 0 always lit.
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nib[i] != '0) begin
        msd = IW'(i);
      end
    end
  end
`endif

  // Next-cycle output values
  logic                  lit;
  logic [NUM_DIGITS-1:0] en_d;

  always_comb begin
    lit = (presc >= GUARD_C);
`ifdef SEG_LZB_EN
    if (idx_q > msd) begin
      lit = 1'b0;
    end
`endif
    en_d = EN_OFF;
    if (lit) begin
      en_d[idx_q] = 1'b0;
    end
  end

  // Output registers
  logic [NIBBLE_W-1:0]   digit_q;
  logic [NUM_DIGITS-1:0] dig_en_q;
  logic                  blank_q;
  logic                  frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      digit_q   <= '0;
      dig_en_q  <= EN_OFF;
      blank_q   <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      digit_q   <= nib[idx_q];
      dig_en_q  <= en_d;
      blank_q   <= &en_d;
      frame_q   <= boundary;
    end
  end

  assign digit   = digit_q;
  assign dig_en  = dig_en_q;
  assign blank   = blank_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan (4 digits, 8-cycle slots, 2 guard cycles).
// Expected outputs come from the cycle count since reset and a value-level model of
// the shadow/display/pending behaviour. Honours SEG_LZB_EN like the design.
module tb_seven_segment_scan;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int G  = 2;
  localparam int FL = ND * SD;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  digit;
  logic [3:0]  dig_en;
  logic        blank;
  logic        frame;
  logic        pending;

  seven_segment_scan #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .GUARD      (G)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data_in (data_in),
    .digit   (digit),
    .dig_en  (dig_en),
    .blank   (blank),
    .frame   (frame),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;   // rising edges since reset release
  int last_frame = -1;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_disp   = '0;
  logic        m_pend   = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dig_en"},  16'(dig_en),  16'h000f);
    chk({tag, "_digit"},   16'(digit),   16'h0000);
    chk({tag, "_blank"},   16'(blank),   16'h0001);
    chk({tag, "_frame"},   16'(frame),   16'h0000);
    chk({tag, "_pending"}, 16'(pending), 16'h0000);
  endtask

  // One clock edge: sample inputs, advance the model, then compare all outputs.
  task automatic step();
    logic        ld;
    logic [15:0] d;
    logic [15:0] disp_old;
    logic [3:0]  one;
    logic [3:0]  exp_en;
    logic [3:0]  exp_digit;
    int          s, presc, idx;
    bit          lit, bnd;
    ld = load;
    d  = data_in;
    @(posedge clk);
    n++;
    s     = n - 1;
    presc = s % SD;
    idx   = (s / SD) % ND;
    bnd   = (n % FL) == 0;
    disp_old = m_disp;
    if (bnd && ld) begin
      m_disp   = d;
      m_shadow = d;
      m_pend   = 1'b0;
    end else begin
      if (bnd && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_shadow = d;
        m_pend   = 1'b1;
      end
    end
    lit = presc >= G;
`ifdef SEG_LZB_EN
    if (idx > 0 && (disp_old >> (4 * idx)) == 16'h0000) lit = 1'b0;
`endif
    one       = 4'b0001;
    exp_en    = lit ? ~(one << idx) : 4'b1111;
    exp_digit = 4'((disp_old >> (4 * idx)) & 16'h000f);
    #1;
    chk("digit",   16'(digit),   16'(exp_digit));
    chk("dig_en",  16'(dig_en),  16'(exp_en));
    chk("blank",   16'(blank),   16'(!lit));
    chk("frame",   16'(frame),   16'(bnd));
    chk("pending", 16'(pending), 16'(m_pend));
    if (frame === 1'b1) begin
      if (last_frame >= 0) chk("frame_gap", 16'(n - last_frame), 16'(FL));
      last_frame = n;
    end
    load = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    load    = 1'b1;
    data_in = v;
    step();
  endtask

  // Run until the next edge is a frame boundary.
  task automatic run_to_boundary();
    while (((n + 1) % FL) != 0) step();
  endtask

  task automatic model_reset();
    n          = 0;
    last_frame = -1;
    m_shadow   = '0;
    m_disp     = '0;
    m_pend     = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    model_reset();

    // First value: pending until the boundary, then shown digit by digit.
    do_load(16'h1234);
    run(FL * 2);

    // Async reset mid-slot while a digit is lit and a new value is pending.
    do_load(16'h9999);
    while ((n % SD) != 4) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("held_rst");
    rst_n = 1'b1;
    model_reset();
    run(3);

    // Two loads in one frame: only the last one is displayed.
    run_to_boundary();
    run(5);
    do_load(16'hAAAA);
    run(7);
    do_load(16'h5555);
    run_to_boundary();
    run(FL + 1);

    // Load on the boundary cycle itself bypasses the shadow.
    run_to_boundary();
    do_load(16'hBEEF);
    chk("bypass_pending", 16'(pending), 16'h0000);
    run(FL + 2);

    // Leading-zero case.
    do_load(16'h0070);
    run_to_boundary();
    run(FL + 1);

    // Zero value.
    do_load(16'h0000);
    run_to_boundary();
    run(FL + 1);

    // Randomised loads, including some landing on boundaries.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        load    = 1'b1;
        data_in = 16'($urandom);
        if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00ff;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
